click_event_counter: RTL
========================

Name: click_event_counter

Overview:
Parametrised successor to the 8-bit loadable counter. Integrates a button front end (2-flop synchroniser, debouncer and rising-edge pulse generator) with a WIDTH-bit up/down counter. The counter steps either every enabled cycle or once per debounced click, and wraps or saturates at its limits. It provides a compare-match flag and a terminal-count pulse, and sits between raw panel buttons and downstream control or display logic.

Parameters:
WIDTH, 8, counter and compare width (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes (>=2); counter width derived internally via $clog2
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
click  input  1  raw asynchronous button level
en  input  1  count enable
mode  input  1  0 = step every cycle while en; 1 = step on each debounced click pulse while en
up_dn  input  1  1 = increment, 0 = decrement
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
cmp_val  input  WIDTH  compare value
count_val  output  WIDTH  registered counter value
match  output  1  combinational, count_val == cmp_val
tc  output  1  registered one-cycle terminal-count pulse
click_pulse  output  1  registered one-cycle pulse per debounced press

Behaviour:
- Reset: rst=1 asynchronously clears count_val, tc, click_pulse, both synchroniser flops, debounced level and debounce counter to 0. match then reflects 0 == cmp_val. Deasserting rst mid-debounce discards all progress.
- Synchroniser: click passes through 2 flops to produce sync.
- Debouncer:
  - If sync != debounced level, the debounce counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, the level takes sync and the counter clears.
  - Any cycle with sync == level clears the counter.
- click_pulse: asserted for exactly 1 cycle, registered on the same edge where the level goes 0->1. With click held high, it is high after the (2+DEBOUNCE_CYCLES)th rising edge that samples click high. A release never produces a pulse. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse.
- Step condition: step = en & (mode ? click_pulse : 1). count_val updates on the edge after step is seen, i.e. 1 cycle after click_pulse.
- Priority: load > step.
  - load=1: count_val <= load_val and tc <= 0, regardless of en, mode or step.
- Up step: count_val < MAX gives +1. count_val == MAX gives 0 (SATURATE=0) or holds MAX (SATURATE=1), with tc <= 1.
- Down step: count_val > 0 gives -1. count_val == 0 gives MAX (SATURATE=0) or holds 0 (SATURATE=1), with tc <= 1.
- tc: asserted on every attempted step at a limit, including repeated attempts while saturated. Otherwise 0 on the next edge.
- No step and no load: count_val holds, tc <= 0.
- up_dn may change any cycle; it takes effect on the next step.
- All arithmetic is modulo 2^WIDTH; MAX = 2^WIDTH-1.

Test Plan:
1. Async reset (WIDTH=8, DEBOUNCE_CYCLES=4): count_val=0x3C, assert rst between edges -> count_val, tc and click_pulse read 0 before the next edge; match=1 with cmp_val=0x00.
2. Debounced click: mode=1, en=1, up_dn=1, count_val=0, click high for 10 cycles -> click_pulse high only after the 6th edge; count_val=0x01 one edge later. A 3-cycle click glitch -> no pulse, count_val stays 0x01. Release -> no pulse.
3. Wrap up: SATURATE=0, mode=0, load 0xFE, then en=1 for 2 cycles -> 0xFF, then 0x00 with tc=1 for exactly 1 cycle; match=1 at 0x00 with cmp_val=0x00.
4. Saturate down: SATURATE=1, load 0x01, up_dn=0, en=1 for 3 cycles -> 0x00, 0x00, 0x00; tc=0, then 1, then 1.
5. Load vs step: mode=0, en=1, count_val=0xFF up, load=1 with load_val=0x55 -> count_val=0x55, tc=0; next cycle with load=0 -> 0x56.
6. Reset mid-debounce: click high for 3 edges, pulse rst, click still high -> click_pulse occurs exactly 6 edges after rst deasserts, not earlier.

Source files
------------

// File: rtl/click_event_counter.sv
// click_event_counter: button front end (2-flop synchroniser, debouncer,
// rising-edge pulse) feeding a WIDTH-bit loadable up/down counter that
// wraps or saturates at its limits, with compare-match and terminal-count.
module click_event_counter #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SATURATE        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             click,
  input  logic             en,
  input  logic             mode,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count_val,
  output logic             match,
  output logic             tc,
  output logic             click_pulse
);

  localparam int             DW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  logic          sync_q1;
  logic          sync_q2;
  logic          level;
  logic [DW-1:0] db_cnt;
  logic          differs;
  logic          db_fire;
  logic          step;

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  // Bring the raw button level into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= click;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce qualifiers: level flips once sync has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    differs = (sync_q2 != level);
    db_fire = differs && (db_cnt == DB_LAST);
  end

  // Debounced level, stability counter and press pulse (press only, never release).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level       <= 1'b0;
      db_cnt      <= '0;
      click_pulse <= 1'b0;
    end else begin
      click_pulse <= db_fire && sync_q2;
      if (db_fire) begin
        level  <= sync_q2;
        db_cnt <= '0;
      end else if (differs) begin
        db_cnt <= db_cnt + 1'b1;
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Counter next state: load beats step; a step at a limit wraps or holds and flags tc.
  always_comb begin
    count_nxt = count_val;
    tc_nxt    = 1'b0;
    step      = en && (mode ? click_pulse : 1'b1);
    if (load) begin
      count_nxt = load_val;
    end else if (step) begin
      if (up_dn) begin
        if (count_val == CNT_MAX) begin
          tc_nxt    = 1'b1;
          count_nxt = (SATURATE != 0) ? CNT_MAX : CNT_MIN;
        end else begin
          count_nxt = count_val + 1'b1;
        end
      end else begin
        if (count_val == CNT_MIN) begin
          tc_nxt    = 1'b1;
          count_nxt = (SATURATE != 0) ? CNT_MIN : CNT_MAX;
        end else begin
          count_nxt = count_val - 1'b1;
        end
      end
    end
  end

  // Counter and terminal-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_val <= '0;
      tc        <= 1'b0;
    end else begin
      count_val <= count_nxt;
      tc        <= tc_nxt;
    end
  end

  // Compare-match is purely combinational on the registered count.
  always_comb begin
    match = (count_val == cmp_val);
  end

endmodule
